// File: rtl/rtc_lectura_pkg.sv
// Shared types and constants for the RTC periodic read sequencer.
package rtc_pkg;
  typedef enum logic [2:0] {ESPERA, DIR, PAUSA1, DATO, PAUSA2} estado_t;

  localparam logic [7:0] DIR_SEG_DEF = 8'h21;
  localparam logic [7:0] DIR_MIN_DEF = 8'h22;
  localparam logic [7:0] DIR_HOR_DEF = 8'h23;

  localparam logic [7:0] MASK_SM  = 8'h7F;
  localparam logic [7:0] MASK_HOR = 8'h3F;
  localparam logic [7:0] LIM_SM   = 8'h59;
  localparam logic [7:0] LIM_HOR  = 8'h23;

  localparam logic [1:0] IDX_SEG = 2'd0;
  localparam logic [1:0] IDX_MIN = 2'd1;
  localparam logic [1:0] IDX_HOR = 2'd2;
endpackage

// File: rtl/rtc_lectura_if.sv
// Multiplexed address/data bus to the external RTC chip.
interface rtc_lectura_if;
  logic [7:0] AD_in;
  logic [7:0] AD_out;
  logic       AD_oe;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A_D;

  modport master (input AD_in, output AD_out, AD_oe, CS_n, RD_n, WR_n, A_D);
  modport slave  (output AD_in, input AD_out, AD_oe, CS_n, RD_n, WR_n, A_D);
endinterface

// File: rtl/rtc_lectura_bcd_valida.sv
// Masks a raw RTC byte by register type and range-checks it as BCD.
module bcd_valida
  import rtc_pkg::*;
(
  input  logic [7:0] dato_in,
  input  logic [1:0] idx,
  output logic [7:0] dato_mask,
  output logic       valido
);
  logic es_hor;

  assign es_hor    = (idx == IDX_HOR);
  assign dato_mask = dato_in & (es_hor ? MASK_HOR : MASK_SM);
  assign valido    = (dato_mask[3:0] <= 4'd9) && (dato_mask <= (es_hor ? LIM_HOR : LIM_SM));
endmodule

// File: rtl/rtc_lectura.sv
// Periodic burst reader of seconds/minutes/hours from the RTC bus, with
// BCD validation and one-cycle update strobes toward the time registers.
module rtc_lectura
  import rtc_pkg::*;
#(
  parameter int unsigned PERIODO_LECT = 100000,
  parameter int unsigned T_PULSO      = 4,
  parameter logic [7:0]  DIR_SEG      = DIR_SEG_DEF,
  parameter logic [7:0]  DIR_MIN      = DIR_MIN_DEF,
  parameter logic [7:0]  DIR_HOR      = DIR_HOR_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Modificando,
  rtc_lectura_if.master  bus,
  output logic [7:0]     DATA_out,
  output logic           Act_seg,
  output logic           Act_min,
  output logic           Act_hor,
  output logic           Err_bcd,
  output logic           Ocupado
);
  localparam int              PW       = $clog2(PERIODO_LECT);
  localparam logic [PW-1:0]   PER_MAX  = PW'(PERIODO_LECT - 1);
  localparam logic [3:0]      FASE_MAX = 4'(T_PULSO - 1);

  estado_t       estado_q, estado_d;
  logic [PW-1:0] per_q, per_d;
  logic [3:0]    fase_q, fase_d;
  logic [1:0]    idx_q, idx_d;
  logic          aborta_q, aborta_d;
  logic [7:0]    dato_q, dato_d;
  logic [2:0]    act_q, act_d;
  logic          err_q, err_d;
  logic          ocup_q, ocup_d;
  logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic          a_d_q, a_d_d, oe_q, oe_d;
  logic [7:0]    ad_out_q, ad_out_d;

  logic [7:0]    dato_mask;
  logic          valido, fin_fase, cancela;

  bcd_valida u_bcd (.dato_in(bus.AD_in), .idx(idx_q), .dato_mask(dato_mask), .valido(valido));

  assign fin_fase = (fase_q == FASE_MAX);
  // An edit seen at any point of the burst cancels the byte in flight.
  assign cancela  = aborta_q | Modificando;

  always_comb begin
    estado_d = estado_q;
    per_d    = (per_q == PER_MAX) ? '0 : per_q + PW'(1);
    fase_d   = fin_fase ? 4'd0 : fase_q + 4'd1;
    idx_d    = idx_q;
    dato_d   = dato_q;
    act_d    = 3'b000;
    err_d    = 1'b0;
    case (estado_q)
      ESPERA: begin
        fase_d = 4'd0;
        if (per_q == PER_MAX) begin
          if (!Modificando) begin
            estado_d = DIR;
            per_d    = '0;
            idx_d    = IDX_SEG;
          end else begin
            per_d    = per_q;
          end
        end
      end
      DIR:    if (fin_fase) estado_d = PAUSA1;
      PAUSA1: if (fin_fase) estado_d = DATO;
      DATO: if (fin_fase) begin
        estado_d = PAUSA2;
        if (!cancela) begin
          if (valido) begin
            dato_d = dato_mask;
            act_d  = 3'b001 << idx_q;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      PAUSA2: if (fin_fase) begin
        if (cancela || idx_q == IDX_HOR) begin
          estado_d = ESPERA;
          idx_d    = IDX_SEG;
          if (cancela) per_d = '0;
        end else begin
          estado_d = DIR;
          idx_d    = idx_q + 2'd1;
        end
      end
      default: estado_d = ESPERA;
    endcase
    aborta_d = (estado_d != ESPERA) && cancela;
  end

  // Bus strobes are decoded from the next state so they leave flops aligned with estado_q.
  always_comb begin
    cs_n_d   = !(estado_d == DIR || estado_d == DATO);
    wr_n_d   = (estado_d != DIR);
    rd_n_d   = (estado_d != DATO);
    a_d_d    = (estado_d != DIR);
    oe_d     = (estado_d == DIR);
    ocup_d   = (estado_d != ESPERA);
    ad_out_d = 8'h00;
    if (estado_d == DIR) begin
      case (idx_d)
        IDX_SEG: ad_out_d = DIR_SEG;
        IDX_MIN: ad_out_d = DIR_MIN;
        default: ad_out_d = DIR_HOR;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      estado_q <= ESPERA;
      per_q    <= '0;
      fase_q   <= 4'd0;
      idx_q    <= IDX_SEG;
      aborta_q <= 1'b0;
      dato_q   <= 8'h00;
      act_q    <= 3'b000;
      err_q    <= 1'b0;
      ocup_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      a_d_q    <= 1'b1;
      oe_q     <= 1'b0;
      ad_out_q <= 8'h00;
    end else begin
      estado_q <= estado_d;
      per_q    <= per_d;
      fase_q   <= fase_d;
      idx_q    <= idx_d;
      aborta_q <= aborta_d;
      dato_q   <= dato_d;
      act_q    <= act_d;
      err_q    <= err_d;
      ocup_q   <= ocup_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      a_d_q    <= a_d_d;
      oe_q     <= oe_d;
      ad_out_q <= ad_out_d;
    end
  end

  assign bus.CS_n   = cs_n_q;
  assign bus.WR_n   = wr_n_q;
  assign bus.RD_n   = rd_n_q;
  assign bus.A_D    = a_d_q;
  assign bus.AD_oe  = oe_q;
  assign bus.AD_out = ad_out_q;
  assign DATA_out   = dato_q;
  assign Act_seg    = act_q[0];
  assign Act_min    = act_q[1];
  assign Act_hor    = act_q[2];
  assign Err_bcd    = err_q;
  assign Ocupado    = ocup_q;
endmodule

// File: tb/tb_rtc_lectura.sv
// Directed bench for rtc_lectura: RTC bus model plus per-cycle burst window checks.
module tb_rtc_lectura;
  localparam int P = 64;
  localparam int T = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Modificando = 1'b0;
  logic [7:0] DATA_out;
  logic       Act_seg, Act_min, Act_hor, Err_bcd, Ocupado;
  logic [7:0] v_seg, v_min, v_hor, rtc_addr;
  int         n_tests = 0;
  int         n_fail  = 0;

  rtc_lectura_if bus ();

  rtc_lectura #(.PERIODO_LECT(P), .T_PULSO(T)) dut (
    .CLK(CLK), .RST(RST), .Modificando(Modificando), .bus(bus),
    .DATA_out(DATA_out), .Act_seg(Act_seg), .Act_min(Act_min), .Act_hor(Act_hor),
    .Err_bcd(Err_bcd), .Ocupado(Ocupado)
  );

  always #5 CLK = ~CLK;

  // RTC chip model: latch address on write strobe, return its byte afterwards.
  always @(posedge CLK or negedge RST)
    if (!RST) rtc_addr <= 8'h00;
    else if (!bus.CS_n && !bus.WR_n) rtc_addr <= bus.AD_out;

  assign bus.AD_in = (rtc_addr == 8'h21) ? v_seg :
                     (rtc_addr == 8'h22) ? v_min :
                     (rtc_addr == 8'h23) ? v_hor : 8'hFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input int maxc, output int w);
    w = 0;
    for (int i = 1; i <= maxc && w == 0; i++) begin
      @(negedge CLK);
      if (Ocupado) w = i;
    end
    if (w == 0) chk("start_seen", 32'(Ocupado), 32'd1);
  endtask

  // Checks cycles 1..49 of a burst against the phase windows; nreg = registers actually read.
  task automatic run_burst(input int maxw, input int exp_w, input int nreg,
                           input logic [2:0] eact, input logic [2:0] eerr,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int mod_at);
    int w, k, ph;
    logic busy;
    logic [4:0] ebus;
    logic [3:0] estb;
    logic [7:0] ed [3];
    ed[0] = d0; ed[1] = d1; ed[2] = d2;
    wait_start(maxw, w);
    chk("latency", 32'(w), 32'(exp_w));
    for (int c = 1; c <= 49; c++) begin
      if (c > 1) @(negedge CLK);
      k    = (c - 1) / (4 * T);
      ph   = ((c - 1) / T) % 4;
      busy = (c <= 4 * T * nreg);
      ebus = !busy ? 5'b11110 : (ph == 0) ? 5'b00101 : (ph == 2) ? 5'b01010 : 5'b11110;
      chk($sformatf("bus c%0d", c), 32'({bus.CS_n, bus.WR_n, bus.RD_n, bus.A_D, bus.AD_oe}), 32'(ebus));
      chk($sformatf("ocupado c%0d", c), 32'(Ocupado), 32'(busy));
      if (busy && ph == 0) chk($sformatf("ad_out c%0d", c), 32'(bus.AD_out), 32'(33 + k));
      estb = 4'b0000;
      if (busy && c == 4 * T * k + 3 * T + 1) begin
        estb[3:1] = eact[k] ? (3'b001 << k) : 3'b000;
        estb[0]   = eerr[k];
        chk($sformatf("data c%0d", c), 32'(DATA_out), 32'(ed[k]));
      end
      chk($sformatf("strobes c%0d", c), 32'({Act_hor, Act_min, Act_seg, Err_bcd}), 32'(estb));
      if (c == mod_at) Modificando = 1'b1;
    end
  endtask

  initial begin
    int w;
    logic seen;
    v_seg = 8'h45; v_min = 8'h37; v_hor = 8'h12;
    repeat (3) @(negedge CLK);
    chk("rst bus", 32'({bus.CS_n, bus.WR_n, bus.RD_n, bus.A_D, bus.AD_oe}), 32'h1E);
    chk("rst ad_out", 32'(bus.AD_out), 32'h00);
    chk("rst data", 32'(DATA_out), 32'h00);
    chk("rst strobes", 32'({Act_hor, Act_min, Act_seg, Err_bcd, Ocupado}), 32'h00);
    RST = 1'b1;

    run_burst(200, 64, 3, 3'b111, 3'b000, 8'h45, 8'h37, 8'h12, 0);
    v_hor = 8'hE3;
    run_burst(100, 16, 3, 3'b111, 3'b000, 8'h45, 8'h37, 8'h23, 0);
    v_hor = 8'h24;
    run_burst(100, 16, 3, 3'b011, 3'b100, 8'h45, 8'h37, 8'h37, 0);
    v_seg = 8'hD8; v_min = 8'h3A; v_hor = 8'h12;
    run_burst(100, 16, 3, 3'b101, 3'b010, 8'h58, 8'h58, 8'h12, 0);

    // Edit starts in cycle 20: minutes read without strobe, hours skipped.
    v_seg = 8'h07; v_min = 8'h37;
    run_burst(100, 16, 2, 3'b001, 3'b000, 8'h07, 8'h07, 8'h00, 19);
    seen = 1'b0;
    repeat (200) begin
      @(negedge CLK);
      if (Ocupado) seen = 1'b1;
    end
    chk("edit hold idle", 32'(seen), 32'd0);
    Modificando = 1'b0;
    v_seg = 8'h30; v_min = 8'h15; v_hor = 8'h09;
    run_burst(10, 1, 3, 3'b111, 3'b000, 8'h30, 8'h15, 8'h09, 0);

    // Asynchronous reset in cycle 10 of a burst.
    wait_start(100, w);
    chk("latency pre-reset", 32'(w), 32'd16);
    repeat (9) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("async bus", 32'({bus.CS_n, bus.WR_n, bus.RD_n, bus.A_D, bus.AD_oe}), 32'h1E);
    chk("async data", 32'(DATA_out), 32'h00);
    chk("async flags", 32'({Act_hor, Act_min, Act_seg, Err_bcd, Ocupado}), 32'h00);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    run_burst(200, 64, 3, 3'b111, 3'b000, 8'h30, 8'h15, 8'h09, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
